// File: rtl/clock_pkg.sv
// Shared types, BCD limits and BCD step helpers for the clock/alarm datapath.
package clock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_t;

    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] SEC_MAX = 8'h59;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] to_bcd(input int unsigned n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX; carry flags the MAX->00 increment.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            value_reg <= 8'h00;
        else if (clr)
            value_reg <= 8'h00;
        else if (inc)
            value_reg <= bcd_inc(value_reg, MAX);
        else if (dec)
            value_reg <= bcd_dec(value_reg, MAX);
    end

    assign value = value_reg;
    assign carry = inc && !clr && (value_reg == MAX);

endmodule

// File: rtl/time_alarm_core.sv
// Running time HH:MM:SS and alarm HH:MM in BCD, with adjust, alarm ring/timeout and display mux.
module time_alarm_core
    import clock_pkg::*;
#(
    parameter int HOUR_MAX      = 23,
    parameter int ALARM_TIMEOUT = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       run,
    input  logic       sel_alarm,
    input  logic       adj_hour,
    input  logic       adj_min,
    input  logic       updown,
    input  logic       alarm_ack,
    output logic [7:0] disp_hh,
    output logic [7:0] disp_mm,
    output logic       sec_led,
    output logic       alarm_active,
    output logic       alarm_blink
);

    localparam logic [7:0] HOUR_MAX_BCD = to_bcd(HOUR_MAX);
    localparam int         CW           = $clog2(ALARM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST      = CW'(ALARM_TIMEOUT - 1);

    logic       tick_ok, adj_hr_req, adj_min_req;
    logic       t_hr_adj, t_min_adj, a_hr_adj, a_min_adj;
    logic [7:0] sec_value, min_value, hr_value, alarm_min, alarm_hr;
    logic       sec_carry, min_carry;
    logic       hr_carry_unused, amin_carry_unused, ahr_carry_unused;

    assign tick_ok     = tick_1hz & run;
    assign adj_hr_req  = ~run & adj_hour;
    assign adj_min_req = ~run & adj_min & ~adj_hour;   // hour wins a simultaneous request
    assign t_hr_adj    = adj_hr_req & ~sel_alarm;
    assign t_min_adj   = adj_min_req & ~sel_alarm;
    assign a_hr_adj    = adj_hr_req & sel_alarm;
    assign a_min_adj   = adj_min_req & sel_alarm;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .inc(tick_ok), .dec(1'b0), .clr(t_min_adj),
        .value(sec_value), .carry(sec_carry));

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .inc(sec_carry | (t_min_adj & updown)),
        .dec(t_min_adj & ~updown), .clr(1'b0),
        .value(min_value), .carry(min_carry));

    bcd_mod_counter #(.MAX(HOUR_MAX_BCD)) u_hr (
        .clk(clk), .rst(rst), .inc((sec_carry & min_carry) | (t_hr_adj & updown)),
        .dec(t_hr_adj & ~updown), .clr(1'b0),
        .value(hr_value), .carry(hr_carry_unused));

    bcd_mod_counter #(.MAX(MIN_MAX)) u_alarm_min (
        .clk(clk), .rst(rst), .inc(a_min_adj & updown), .dec(a_min_adj & ~updown),
        .clr(1'b0), .value(alarm_min), .carry(amin_carry_unused));

    bcd_mod_counter #(.MAX(HOUR_MAX_BCD)) u_alarm_hr (
        .clk(clk), .rst(rst), .inc(a_hr_adj & updown), .dec(a_hr_adj & ~updown),
        .clr(1'b0), .value(alarm_hr), .carry(ahr_carry_unused));

    // Match against the time the tick is about to produce, not the current one.
    logic [7:0] next_min, next_hr;
    logic       trigger;

    always_comb begin
        next_min = sec_carry ? bcd_inc(min_value, MIN_MAX) : min_value;
        next_hr  = (sec_carry && min_value == MIN_MAX) ? bcd_inc(hr_value, HOUR_MAX_BCD) : hr_value;
        trigger  = sec_carry && (next_min == alarm_min) && (next_hr == alarm_hr);
    end

    alarm_state_t  state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          blink_reg, blink_next;
    logic          sec_led_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            blink_reg   <= 1'b0;
            sec_led_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            blink_reg   <= blink_next;
            sec_led_reg <= sec_led_reg ^ tick_ok;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        blink_next = blink_reg;
        case (state_reg)
            IDLE: begin
                if (trigger && !alarm_ack) begin
                    state_next = RING;
                    count_next = '0;
                    blink_next = 1'b0;
                end
            end
            RING: begin
                if (alarm_ack || !run) begin
                    state_next = IDLE;
                    blink_next = 1'b0;
                end else if (tick_ok) begin
                    if (count_reg == LAST) begin
                        state_next = IDLE;
                        blink_next = 1'b0;
                    end else begin
                        count_next = count_reg + 1'b1;
                        blink_next = ~blink_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sec_led      = sec_led_reg;
    assign alarm_active = (state_reg == RING);
    assign alarm_blink  = blink_reg;
    assign disp_hh      = (!run && sel_alarm) ? alarm_hr  : hr_value;
    assign disp_mm      = (!run && sel_alarm) ? alarm_min : min_value;

endmodule

// File: tb/tb_time_alarm_core.sv
// Scoreboard bench: stimulus updates a seconds-of-day reference model and queues the expected outputs.
module tb_time_alarm_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0, run = 1'b0, sel_alarm = 1'b0;
    logic       adj_hour = 1'b0, adj_min = 1'b0, updown = 1'b0, alarm_ack = 1'b0;
    logic [7:0] disp_hh, disp_mm;
    logic       sec_led, alarm_active, alarm_blink;

    always #5 clk = ~clk;

    time_alarm_core dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .run(run), .sel_alarm(sel_alarm),
        .adj_hour(adj_hour), .adj_min(adj_min), .updown(updown), .alarm_ack(alarm_ack),
        .disp_hh(disp_hh), .disp_mm(disp_mm), .sec_led(sec_led),
        .alarm_active(alarm_active), .alarm_blink(alarm_blink));

    typedef struct {
        logic [7:0] hh;
        logic [7:0] mm;
        logic       led;
        logic       act;
        logic       blink;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    // Reference model: time as seconds of day, alarm as minutes of day.
    int   t = 0, a = 0, ring = 0, cnt = 0;
    logic led_m = 1'b0, blink_m = 1'b0;

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic cyc(input logic r, input logic tk, input logic rn, input logic sl,
                       input logic ah, input logic am, input logic ud, input logic ak);
        exp_t e;
        logic trig;
        @(negedge clk);
        rst = r; tick_1hz = tk; run = rn; sel_alarm = sl;
        adj_hour = ah; adj_min = am; updown = ud; alarm_ack = ak;
        trig = 1'b0;
        if (!r) begin
            t = 0; a = 0; ring = 0; cnt = 0; led_m = 1'b0; blink_m = 1'b0;
        end else begin
            if (tk && rn) begin
                led_m = ~led_m;
                t = (t + 1) % 86400;
                trig = (t % 60 == 0) && (t / 60 == a);
            end else if (!rn) begin
                if (ah) begin
                    if (sl) a = (((a / 60) + (ud ? 1 : 23)) % 24) * 60 + (a % 60);
                    else    t = (t + (ud ? 3600 : 86400 - 3600)) % 86400;
                end else if (am) begin
                    if (sl) a = (a / 60) * 60 + (((a % 60) + (ud ? 1 : 59)) % 60);
                    else    t = (t / 3600) * 3600 + ((((t / 60) % 60) + (ud ? 1 : 59)) % 60) * 60;
                end
            end
            if (ring == 0) begin
                if (trig && !ak) begin
                    ring = 1; cnt = 0; blink_m = 1'b0;
                end
            end else if (ak || !rn) begin
                ring = 0; blink_m = 1'b0;
            end else if (tk) begin
                cnt++;
                if (cnt == 60) begin
                    ring = 0; blink_m = 1'b0;
                end else begin
                    blink_m = ~blink_m;
                end
            end
        end
        if (!rn && sl) begin
            e.hh = bcd(a / 60);
            e.mm = bcd(a % 60);
        end else begin
            e.hh = bcd(t / 3600);
            e.mm = bcd((t / 60) % 60);
        end
        e.led = led_m;
        e.act = (ring != 0);
        e.blink = blink_m;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s txn %0d got %h want %h", name, txn, act, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d hh=%h mm=%h led=%b act=%b blink=%b", txn, disp_hh, disp_mm,
                     sec_led, alarm_active, alarm_blink);
            chk("disp_hh", disp_hh, e.hh);
            chk("disp_mm", disp_mm, e.mm);
            chk("sec_led", {7'd0, sec_led}, {7'd0, e.led});
            chk("alarm_active", {7'd0, alarm_active}, {7'd0, e.act});
            chk("alarm_blink", {7'd0, alarm_blink}, {7'd0, e.blink});
        end
    end

    // Pull the time back to hh:29:00 so 60 ticks later it reaches hh:30:00 (alarm at 07:30).
    task automatic arm();
        while (((t / 60) % 60) != 29) cyc(1, 0, 0, 0, 0, 1, 0, 0);
        repeat (60) cyc(1, 1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // wraps on decrement, and hour priority over minute
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 1, 0);
        // 23:59:00 -> 23:59:58 -> rollover (also meets the 00:00 alarm)
        repeat (58) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        // alarm 07:30, time 07:29:00 -> 07:29:59 -> trigger -> ack
        repeat (7) cyc(1, 0, 0, 1, 1, 0, 1, 0);
        repeat (30) cyc(1, 0, 0, 1, 0, 1, 1, 0);
        repeat (7) cyc(1, 0, 0, 0, 1, 0, 1, 0);
        repeat (29) cyc(1, 0, 0, 0, 0, 1, 1, 0);
        repeat (60) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        // timeout with no ack
        arm();
        repeat (62) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        // leave run mid-ring
        arm();
        repeat (5) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-ring
        arm();
        repeat (3) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        // adjusts ignored while running, then alarm shown immediately in adjust mode
        repeat (3) cyc(1, 0, 0, 1, 0, 1, 1, 0);
        repeat (4) cyc(1, 0, 1, 0, 0, 1, 1, 0);
        repeat (2) cyc(1, 1, 1, 1, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic rn;
            rn = ($urandom_range(0, 3) != 0);
            cyc(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), rn,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0));
        end
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/time_alarm_core.md
# time_alarm_core

Time-keeping and alarm datapath that executes the adjust commands issued by the mode/button FSM. It holds the running time (HH:MM:SS) and the alarm setting (HH:MM) as BCD digits. It applies run ticks and up/down adjust pulses, raises and clears the alarm, and presents the selected HH:MM to the seven-segment multiplexer. It sits between the 1 Hz divider and mode FSM on the input side and the display driver and LEDs on the output side.

## Interface
- `HOUR_MAX`, 23: highest hour value; the hour wraps `HOUR_MAX` ↔ 0.
- `ALARM_TIMEOUT`, 60: number of accepted ticks after which a ringing alarm stops by itself.
- `clk` in 1: the single clock; all logic is clocked on its rising edge.
- `rst` in 1: active-low, synchronous reset; sampled on the `clk` rising edge.
- `tick_1hz` in 1: one-cycle enable pulse, one per second.
- `run` in 1: 1 = time advances on ticks; 0 = adjust mode.
- `sel_alarm` in 1: in adjust mode, 0 = adjust time registers, 1 = adjust alarm registers.
- `adj_hour` in 1: one-cycle request to step the hour by one.
- `adj_min` in 1: one-cycle request to step the minute by one.
- `updown` in 1: adjust direction; 1 = +1, 0 = −1.
- `alarm_ack` in 1: one-cycle request to dismiss the alarm.
- `disp_hh` out 8: two BCD hour digits for the display.
- `disp_mm` out 8: two BCD minute digits for the display.
- `sec_led` out 1: toggles on every accepted tick.
- `alarm_active` out 1: 1 while the alarm is ringing.
- `alarm_blink` out 1: toggles on each accepted tick while ringing; held at 0 otherwise.

## Operation
- Accepted tick: `tick_1hz`=1 and `run`=1.
  - Seconds count 00→59 and carry into minutes.
  - Minutes count 00→59 and carry into hours.
  - Hours count 00→`HOUR_MAX` and wrap to 00 (23:59:59 → 00:00:00).
- Adjust is accepted only when `run`=0. While `run`=1, `adj_*` pulses are ignored.
- `adj_hour` steps the selected hour by ±1 with wrap (0 −1 → `HOUR_MAX`).
- `adj_min` steps the selected minute by ±1 with wrap (00 −1 → 59). It never carries into the hour.
- A time-minute adjust also clears the seconds to 00. Alarm adjusts never touch the seconds.
- If `adj_hour` and `adj_min` arrive in the same cycle, only the hour adjust is applied.
- Digits are stored in BCD throughout. A unit digit of 9 steps to 0 with a tens carry; the reverse applies on decrement. No digit ever holds a value above 9.
- Display mux:
  - If `run`=0 and `sel_alarm`=1, `disp_*` show the alarm HH:MM.
  - Otherwise they show the time HH:MM.
  - The mux is combinational from registers, so it follows `run`/`sel_alarm` in the same cycle.
- Alarm state machine, states IDLE and RING:
  - IDLE→RING on an accepted tick whose next time has seconds = 00 and next HH:MM equals the alarm HH:MM.
  - RING→IDLE on `alarm_ack`.
  - RING→IDLE on `run`=0.
  - RING→IDLE after `ALARM_TIMEOUT` accepted ticks in RING, counted by a timeout counter cleared on entry.
  - If `alarm_ack` arrives in the same cycle as a trigger, the ack wins and the state stays IDLE.
  - Entering adjust mode never triggers the alarm, even when the time equals the alarm.
- Reset (`rst`=0 at a clock edge):
  - Time = 00:00:00; alarm = 00:00.
  - State = IDLE; timeout counter = 0.
  - `sec_led`=0, `alarm_active`=0, `alarm_blink`=0.
  - `disp_hh`=8'h00, `disp_mm`=8'h00.
  - Reset overrides every other input, including in the middle of a ring.

## Timing
- Tick or adjust at edge N: new digits are visible after edge N (1-cycle latency).
- Trigger tick at edge N: `alarm_active`=1 after edge N.
- `alarm_ack` at edge N: `alarm_active`=0 after edge N.
- No handshake: every input pulse is consumed in the cycle it is sampled.
- Back-to-back `adj_*` pulses on consecutive cycles each take effect.
- `tick_1hz` held high for k cycles counts as k ticks; the divider guarantees one-cycle pulses.

## Structure
- Shared package `clock_pkg`:
  - The `alarm_state_t` enum (IDLE, RING).
  - BCD constants: `MIN_MAX`=8'h59, `SEC_MAX`=8'h59.
  - A BCD increment/decrement function pair.
- Sub-module `bcd_mod_counter`:
  - Two-digit BCD counter with parameter MAX.
  - Ports: `inc`, `dec`, `clr`, `value`, and a `carry` output on the MAX→0 wrap.
  - Five instances: sec, min, hr, alarm_min, alarm_hr.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → time 00:00:00, `disp_hh`=00, `disp_mm`=00, `alarm_active`=0.
- Rollover: preset 23:59:58 via adjusts, `run`=1, two ticks → 23:59:59, then 00:00:00; `sec_led` toggles twice.
- Adjust wrap:
  - `run`=0, `sel_alarm`=0, `updown`=0, `adj_hour` at 00 → 23.
  - `adj_min` at 00 → 59, seconds cleared, hour unchanged.
  - `adj_hour` and `adj_min` in the same cycle → only the hour changes.
- Alarm trigger and ack: alarm 07:30, time 07:29:59, one tick → `alarm_active`=1 next cycle; `alarm_ack` → 0 next cycle.
- Timeout and abort:
  - Ringing with no ack → cleared exactly at the 60th accepted tick.
  - `run`=0 mid-ring → IDLE next cycle.
  - `rst`=0 mid-ring → IDLE next cycle.
- Ignored adjust: `run`=1, `adj_min` pulses → no change. Then `run`=0, `sel_alarm`=1 → display switches to the alarm value in the same cycle.
